// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus for regfile_wb_arbiter: two producer handshakes,
// the register-file write port and the read-port bypass signals.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned RW = 6
);
    logic          a_valid;
    logic          a_ready;
    logic [RW-1:0] a_rn;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [RW-1:0] b_rn;
    logic [DW-1:0] b_data;
    logic          w_en;
    logic [RW-1:0] w_rn;
    logic [DW-1:0] w_data;
    logic [RW-1:0] r1_rn;
    logic [RW-1:0] r2_rn;
    logic          r1_fwd;
    logic [DW-1:0] r1_fwd_data;
    logic          r2_fwd;
    logic [DW-1:0] r2_fwd_data;
    logic          busy;

    // Arbiter side: consumes producer results, drives the file write port.
    modport master (
        input  a_valid, a_rn, a_data, b_valid, b_rn, b_data, r1_rn, r2_rn,
        output a_ready, b_ready, w_en, w_rn, w_data,
        output r1_fwd, r1_fwd_data, r2_fwd, r2_fwd_data, busy
    );

    // Producer / register-file side.
    modport slave (
        output a_valid, a_rn, a_data, b_valid, b_rn, b_data, r1_rn, r2_rn,
        input  a_ready, b_ready, w_en, w_rn, w_data,
        input  r1_fwd, r1_fwd_data, r2_fwd, r2_fwd_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: two buffered producers, round-robin retire, one write per cycle.
// Optional read-port bypass outputs are built when RAISIN64_WB_BYPASS_EN is defined.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 64,
    parameter int unsigned RW    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.master  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {PRIO_A, PRIO_B} prio_e;

    logic [RW-1:0] r_a_rn   [DEPTH];
    logic [DW-1:0] r_a_data [DEPTH];
    logic [RW-1:0] r_b_rn   [DEPTH];
    logic [DW-1:0] r_b_data [DEPTH];
    logic [PW-1:0] r_a_wp, r_a_rp, r_b_wp, r_b_rp;
    prio_e         r_prio;
    logic          r_w_en;
    logic [RW-1:0] r_w_rn;
    logic [DW-1:0] r_w_data;

    logic          w_a_empty, w_a_full, w_a_push, w_pop_a;
    logic          w_b_empty, w_b_full, w_b_push, w_pop_b;
    prio_e         w_prio_nxt;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_a_empty = (r_a_wp == r_a_rp);
    assign w_b_empty = (r_b_wp == r_b_rp);
    assign w_a_full  = (r_a_wp[AW] != r_a_rp[AW]) && (r_a_wp[AW-1:0] == r_a_rp[AW-1:0]);
    assign w_b_full  = (r_b_wp[AW] != r_b_rp[AW]) && (r_b_wp[AW-1:0] == r_b_rp[AW-1:0]);

    // r0 results complete the handshake but are dropped.
    assign w_a_push = bus.a_valid && !w_a_full && (bus.a_rn != '0);
    assign w_b_push = bus.b_valid && !w_b_full && (bus.b_rn != '0);

    // Round-robin grant; priority moves only on a contested cycle.
    always_comb begin
        w_pop_a    = 1'b0;
        w_pop_b    = 1'b0;
        w_prio_nxt = r_prio;
        if (!w_a_empty && !w_b_empty) begin
            if (r_prio == PRIO_A) begin
                w_pop_a    = 1'b1;
                w_prio_nxt = PRIO_B;
            end else begin
                w_pop_b    = 1'b1;
                w_prio_nxt = PRIO_A;
            end
        end else if (!w_a_empty) begin
            w_pop_a = 1'b1;
        end else if (!w_b_empty) begin
            w_pop_b = 1'b1;
        end
    end

    // Buffer storage needs no reset: the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_a_push) begin
            r_a_rn[r_a_wp[AW-1:0]]   <= bus.a_rn;
            r_a_data[r_a_wp[AW-1:0]] <= bus.a_data;
        end
        if (w_b_push) begin
            r_b_rn[r_b_wp[AW-1:0]]   <= bus.b_rn;
            r_b_data[r_b_wp[AW-1:0]] <= bus.b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_wp   <= '0;
            r_a_rp   <= '0;
            r_b_wp   <= '0;
            r_b_rp   <= '0;
            r_prio   <= PRIO_A;
            r_w_en   <= 1'b0;
            r_w_rn   <= '0;
            r_w_data <= '0;
        end else begin
            if (w_a_push) r_a_wp <= r_a_wp + PW'(1);
            if (w_b_push) r_b_wp <= r_b_wp + PW'(1);
            if (w_pop_a)  r_a_rp <= r_a_rp + PW'(1);
            if (w_pop_b)  r_b_rp <= r_b_rp + PW'(1);
            r_prio <= w_prio_nxt;
            if (w_pop_a) begin
                r_w_en   <= 1'b1;
                r_w_rn   <= r_a_rn[r_a_rp[AW-1:0]];
                r_w_data <= r_a_data[r_a_rp[AW-1:0]];
            end else if (w_pop_b) begin
                r_w_en   <= 1'b1;
                r_w_rn   <= r_b_rn[r_b_rp[AW-1:0]];
                r_w_data <= r_b_data[r_b_rp[AW-1:0]];
            end else begin
                r_w_en   <= 1'b0;
            end
        end
    end

    assign bus.a_ready = !w_a_full;
    assign bus.b_ready = !w_b_full;
    assign bus.w_en    = r_w_en;
    assign bus.w_rn    = r_w_rn;
    assign bus.w_data  = r_w_data;
    assign bus.busy    = !w_a_empty || !w_b_empty || r_w_en;

`ifdef RAISIN64_WB_BYPASS_EN
    logic          r_r1_fwd, r_r2_fwd;
    logic [DW-1:0] r_r1_fwd_data, r_r2_fwd_data;

    // The file misses a same-edge write, so flag reads that race one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r1_fwd      <= 1'b0;
            r_r2_fwd      <= 1'b0;
            r_r1_fwd_data <= '0;
            r_r2_fwd_data <= '0;
        end else begin
            r_r1_fwd      <= r_w_en && (r_w_rn == bus.r1_rn) && (bus.r1_rn != '0);
            r_r2_fwd      <= r_w_en && (r_w_rn == bus.r2_rn) && (bus.r2_rn != '0);
            r_r1_fwd_data <= r_w_data;
            r_r2_fwd_data <= r_w_data;
        end
    end

    assign bus.r1_fwd      = r_r1_fwd;
    assign bus.r2_fwd      = r_r2_fwd;
    assign bus.r1_fwd_data = r_r1_fwd_data;
    assign bus.r2_fwd_data = r_r2_fwd_data;
`else
    logic w_unused_rn;
    assign w_unused_rn     = ^{bus.r1_rn, bus.r2_rn};
    assign bus.r1_fwd      = 1'b0;
    assign bus.r2_fwd      = 1'b0;
    assign bus.r1_fwd_data = '0;
    assign bus.r2_fwd_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-based model plus directed literal checks.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 64;
    localparam int unsigned RW    = 6;

    typedef struct packed {
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DW(DW), .RW(RW)) bus ();
    regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    ent_t          sa[$];
    ent_t          sb[$];
    ent_t          ma[$];
    ent_t          mb[$];
    logic [RW-1:0] dut_log[$];

    logic          m_prio_b;
    logic          m_wen;
    logic [RW-1:0] m_wrn;
    logic [DW-1:0] m_wdata;
    logic          m_f1, m_f2;
    logic [DW-1:0] m_f1d, m_f2d;

    int   idx, idx2, cnt, last_a, last_b;
    logic ordered, b_stall_seen;
    logic [RW-1:0] exp_rn;

    function automatic ent_t mk(input int rn, input logic [DW-1:0] d);
        ent_t e;
        e.rn   = RW'(rn);
        e.data = d;
        return e;
    endfunction

    // Model: each source is a FIFO of at most DEPTH results; one retire per edge.
    always @(posedge clk or posedge rst) begin : model
        int   na, nb;
        logic acc_a, acc_b;
        ent_t e;
        if (rst) begin
            ma.delete();
            mb.delete();
            m_prio_b = 1'b0;
            m_wen    = 1'b0;
            m_wrn    = '0;
            m_wdata  = '0;
            m_f1     = 1'b0;
            m_f2     = 1'b0;
            m_f1d    = '0;
            m_f2d    = '0;
        end else begin
            na    = ma.size();
            nb    = mb.size();
            acc_a = bus.a_valid && (na < int'(DEPTH));
            acc_b = bus.b_valid && (nb < int'(DEPTH));
`ifdef RAISIN64_WB_BYPASS_EN
            m_f1  = m_wen && (m_wrn == bus.r1_rn) && (bus.r1_rn != '0);
            m_f2  = m_wen && (m_wrn == bus.r2_rn) && (bus.r2_rn != '0);
            m_f1d = m_wdata;
            m_f2d = m_wdata;
`endif
            if (na > 0 && (nb == 0 || !m_prio_b)) begin
                e = ma.pop_front();
                m_wen = 1'b1; m_wrn = e.rn; m_wdata = e.data;
            end else if (nb > 0) begin
                e = mb.pop_front();
                m_wen = 1'b1; m_wrn = e.rn; m_wdata = e.data;
            end else begin
                m_wen = 1'b0;
            end
            if (na > 0 && nb > 0) m_prio_b = !m_prio_b;
            if (acc_a && bus.a_rn != '0) ma.push_back(mk(int'(bus.a_rn), bus.a_data));
            if (acc_b && bus.b_rn != '0) mb.push_back(mk(int'(bus.b_rn), bus.b_data));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.a_valid = (sa.size() > 0);
        bus.b_valid = (sb.size() > 0);
        if (sa.size() > 0) begin bus.a_rn = sa[0].rn; bus.a_data = sa[0].data; end
        else begin bus.a_rn = '0; bus.a_data = '0; end
        if (sb.size() > 0) begin bus.b_rn = sb[0].rn; bus.b_data = sb[0].data; end
        else begin bus.b_rn = '0; bus.b_data = '0; end
    endtask

    task automatic cycle_compare();
        logic m_busy;
        m_busy = (ma.size() > 0) || (mb.size() > 0) || m_wen;
        chk("a_ready", 64'(bus.a_ready), 64'(ma.size() < int'(DEPTH)));
        chk("b_ready", 64'(bus.b_ready), 64'(mb.size() < int'(DEPTH)));
        chk("w_en", 64'(bus.w_en), 64'(m_wen));
        chk("w_rn", 64'(bus.w_rn), 64'(m_wrn));
        chk("w_data", bus.w_data, m_wdata);
        chk("busy", 64'(bus.busy), 64'(m_busy));
        chk("r1_fwd", 64'(bus.r1_fwd), 64'(m_f1));
        chk("r2_fwd", 64'(bus.r2_fwd), 64'(m_f2));
        chk("r1_fwd_data", bus.r1_fwd_data, m_f1d);
        chk("r2_fwd_data", bus.r2_fwd_data, m_f2d);
        if (bus.w_en) dut_log.push_back(bus.w_rn);
        if (!bus.b_ready) b_stall_seen = 1'b1;
    endtask

    // One clock: handshake at the edge, new inputs just after, compare at negedge.
    task automatic step();
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            if (bus.a_valid && bus.a_ready && sa.size() > 0) e = sa.pop_front();
            if (bus.b_valid && bus.b_ready && sb.size() > 0) e = sb.pop_front();
        end
        #1;
        drive();
        @(negedge clk);
        cycle_compare();
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((sa.size() > 0 || sb.size() > 0 || bus.busy) && n < maxc) begin
            step();
            n++;
        end
        chk("drain", 64'(sa.size() == 0 && sb.size() == 0 && !bus.busy), 64'(1));
    endtask

    initial begin
        bus.r1_rn = '0;
        bus.r2_rn = '0;
        b_stall_seen = 1'b0;
        drive();

        // Reset state
        repeat (2) @(negedge clk);
        cycle_compare();
        chk("rst_w_en", 64'(bus.w_en), 64'(0));
        chk("rst_a_ready", 64'(bus.a_ready), 64'(1));
        chk("rst_b_ready", 64'(bus.b_ready), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_r1_fwd", 64'(bus.r1_fwd), 64'(0));
        rst = 1'b0;

        // Single A result: two-cycle latency, one write
        sa.push_back(mk(5, 64'h1234));
        drive();
        step();
        chk("t1_busy_buffered", 64'(bus.busy), 64'(1));
        step();
        chk("t1_w_en", 64'(bus.w_en), 64'(1));
        chk("t1_w_rn", 64'(bus.w_rn), 64'(5));
        chk("t1_w_data", bus.w_data, 64'h1234);
        step();
        chk("t1_w_en_drop", 64'(bus.w_en), 64'(0));
        chk("t1_busy_idle", 64'(bus.busy), 64'(0));

        // Both sources every cycle: strict A,B alternation
        bus.r1_rn = 6'd3;
        bus.r2_rn = 6'd12;
        idx = dut_log.size();
        for (int i = 0; i < 8; i++) begin
            sa.push_back(mk(i + 1, 64'hA000 + 64'(i + 1)));
            sb.push_back(mk(i + 9, 64'hB000 + 64'(i + 9)));
        end
        drive();
        wait_drain(60);
        chk("t2_count", 64'(dut_log.size() - idx), 64'(16));
        for (int i = 0; i < 16; i++) begin
            exp_rn = (i % 2 == 0) ? RW'(i / 2 + 1) : RW'(i / 2 + 9);
            if (idx + i < dut_log.size())
                chk($sformatf("t2_rn%0d", i), 64'(dut_log[idx + i]), 64'(exp_rn));
        end

        // A floods while B is held: B back-pressures, nothing lost
        b_stall_seen = 1'b0;
        idx = dut_log.size();
        for (int r = 20; r <= 25; r++) sa.push_back(mk(r, 64'(r) * 64'h111));
        for (int r = 30; r <= 33; r++) sb.push_back(mk(r, 64'(r) * 64'h111));
        drive();
        wait_drain(60);
        chk("t3_b_ready_low_seen", 64'(b_stall_seen), 64'(1));
        chk("t3_count", 64'(dut_log.size() - idx), 64'(10));
        for (int r = 20; r <= 33; r++) begin
            if (r <= 25 || r >= 30) begin
                cnt = 0;
                for (int i = idx; i < dut_log.size(); i++)
                    if (int'(dut_log[i]) == r) cnt++;
                chk($sformatf("t3_once_rn%0d", r), 64'(cnt), 64'(1));
            end
        end
        last_a = 0; last_b = 0; ordered = 1'b1;
        for (int i = idx; i < dut_log.size(); i++) begin
            if (int'(dut_log[i]) < 30) begin
                if (int'(dut_log[i]) <= last_a) ordered = 1'b0;
                last_a = int'(dut_log[i]);
            end else begin
                if (int'(dut_log[i]) <= last_b) ordered = 1'b0;
                last_b = int'(dut_log[i]);
            end
        end
        chk("t3_per_source_order", 64'(ordered), 64'(1));

        // r0 result: accepted, never written
        sa.push_back(mk(0, 64'hFFFF));
        drive();
        step();
        chk("t4_accepted", 64'(sa.size()), 64'(0));
        chk("t4_busy", 64'(bus.busy), 64'(0));
        step();
        chk("t4_w_en", 64'(bus.w_en), 64'(0));
        chk("t4_busy2", 64'(bus.busy), 64'(0));

        // Reset mid-operation discards buffered results
        for (int i = 0; i < 4; i++) begin
            sa.push_back(mk(40 + i, 64'h4000 + 64'(i)));
            sb.push_back(mk(50 + i, 64'h5000 + 64'(i)));
        end
        drive();
        step(); step(); step();
        chk("t5_w_en_before", 64'(bus.w_en), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("t5_w_en_async", 64'(bus.w_en), 64'(0));
        chk("t5_busy_async", 64'(bus.busy), 64'(0));
        sa.delete();
        sb.delete();
        drive();
        @(negedge clk);
        cycle_compare();
        rst = 1'b0;
        idx2 = dut_log.size();
        step();
        chk("t5_a_ready", 64'(bus.a_ready), 64'(1));
        chk("t5_b_ready", 64'(bus.b_ready), 64'(1));
        repeat (5) step();
        chk("t5_no_stale", 64'(dut_log.size() - idx2), 64'(0));

        // Read-port bypass
        bus.r1_rn = 6'd7;
        bus.r2_rn = 6'd0;
        sa.push_back(mk(7, 64'hABCD));
        drive();
        step(); step();
        chk("t6_w_en", 64'(bus.w_en), 64'(1));
        chk("t6_w_rn", 64'(bus.w_rn), 64'(7));
        chk("t6_w_data", bus.w_data, 64'hABCD);
        step();
`ifdef RAISIN64_WB_BYPASS_EN
        chk("t6_r1_fwd", 64'(bus.r1_fwd), 64'(1));
        chk("t6_r1_fwd_data", bus.r1_fwd_data, 64'hABCD);
        chk("t6_r2_fwd_r0", 64'(bus.r2_fwd), 64'(0));
`else
        chk("t6_r1_fwd_off", 64'(bus.r1_fwd), 64'(0));
        chk("t6_r2_fwd_off", 64'(bus.r2_fwd), 64'(0));
`endif
        bus.r1_rn = 6'd0;
        bus.r2_rn = 6'd7;
        sa.push_back(mk(7, 64'h5678));
        drive();
        step(); step(); step();
`ifdef RAISIN64_WB_BYPASS_EN
        chk("t6_r1_fwd_r0", 64'(bus.r1_fwd), 64'(0));
        chk("t6_r2_fwd", 64'(bus.r2_fwd), 64'(1));
        chk("t6_r2_fwd_data", bus.r2_fwd_data, 64'h5678);
`else
        chk("t6_r1_fwd_off2", 64'(bus.r1_fwd), 64'(0));
        chk("t6_r2_fwd_off2", 64'(bus.r2_fwd), 64'(0));
`endif
        wait_drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the CPU register file: collects results from two producers and drives the file's single write port (w_en/w_rn/w_data).
- Source A is the integer ALU; source B is the load/mem unit.
- Each source has a valid/ready handshake and a small in-order buffer. A round-robin arbiter retires one result per cycle to the file.
- Sits between the execute/mem stages and the register file.

Parameters:
- DEPTH, 2, entries per source buffer; power of 2, minimum 2
- DW, 64, data width
- RW, 6, register-number width (64 architectural registers, r0 hardwired zero)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- a_valid  in  1  source A result valid
- a_ready  out  1  source A may present a result
- a_rn  in  RW  source A destination register
- a_data  in  DW  source A result
- b_valid  in  1  source B result valid
- b_ready  out  1  source B may present a result
- b_rn  in  RW  source B destination register
- b_data  in  DW  source B result
- w_en  out  1  register-file write enable (registered)
- w_rn  out  RW  register-file write register (registered)
- w_data  out  DW  register-file write data (registered)
- r1_rn  in  RW  register file read-port-1 address (bypass compare)
- r2_rn  in  RW  register file read-port-2 address (bypass compare)
- r1_fwd  out  1  forward override valid for read port 1
- r1_fwd_data  out  DW  forward data for read port 1
- r2_fwd  out  1  forward override valid for read port 2
- r2_fwd_data  out  DW  forward data for read port 2
- busy  out  1  any buffer non-empty or w_en high

Behaviour:
- Reset (async, rst=1): both buffers emptied; pointers 0; RR priority set to A; w_en, w_rn, w_data, r1_fwd, r2_fwd, r1_fwd_data, r2_fwd_data all 0. a_ready=b_ready=1 after reset.
- Reset mid-operation: buffered results are discarded, with no write issued. In-flight w_en drops immediately.
- Handshake: transfer occurs on a rising edge with x_valid && x_ready.
  - x_ready = !full_x, registered-state-derived only; there is no combinational path from pop to ready.
  - Producers hold valid/rn/data stable until accepted.
- rn==0 results: accepted (handshake completes) but not enqueued; they never produce a write.
- Buffers: per-source circular FIFO.
  - Read/write pointers are log2(DEPTH)+1 bits; full when MSBs differ and low bits are equal.
  - Push and pop in the same cycle are allowed when non-empty; count is unchanged.
  - A push into a full buffer cannot occur, because ready is low.
- Arbitration, each cycle:
  - If only one buffer is non-empty, it is popped.
  - If both are non-empty, the source holding RR priority is popped, and priority then passes to the other source.
  - If neither is non-empty, nothing is popped.
  - Priority only changes on a contested grant.
- Write port:
  - On a pop edge, w_en<=1, w_rn<=head rn, w_data<=head data.
  - With no pop, w_en<=0; w_rn and w_data hold their values.
  - Maximum one write per cycle.
- Latency: handshake at edge N into an empty, uncontested buffer; w_en high during the cycle after edge N+1. Minimum latency is 2 cycles.
- Throughput: one write per cycle sustained. Each source gets at least 1 of every 2 cycles under contention.
- Ordering:
  - Per source, results are written in acceptance order.
  - There is no ordering between A and B. The issue logic must not let both sources target the same rn with unresolved order.
- busy = |count_a || |count_b || w_en.

Optional Feature:
- Macro: RAISIN64_WB_BYPASS_EN.
- Purpose: the register file registers reads and ignores a same-edge write, so a read issued in the same cycle as w_en returns the stale value.
- Defined: r1_fwd and r1_fwd_data are registered on each edge as follows (port 2 identical using r2_rn):
  - r1_fwd <= w_en && w_rn==r1_rn && r1_rn!=0
  - r1_fwd_data <= w_data
  - These align with the register file's r1_data output; the consumer muxes fwd_data when fwd=1.
- Undefined: r1_fwd, r2_fwd, r1_fwd_data and r2_fwd_data are constant 0, and no comparators are built.

Test Plan:
- Reset, then single A push (rn=5, data=0x1234) at edge 1 -> w_en=1, w_rn=5, w_data=0x1234 for exactly one cycle after edge 2; busy=0 afterwards.
- A and B both push every cycle for 8 cycles (A rn=1..8, B rn=9..16) -> writes alternate A,B,A,B starting with A; each source's rn sequence is in order; 16 writes total.
- Hold B valid with no arbitration loss, DEPTH=2, while A floods -> b_ready deasserts after 2 unretired pushes; no data lost; every pushed rn appears exactly once on w_rn.
- Push A rn=0, data=0xFFFF -> a_ready handshake completes; w_en stays 0; busy stays 0.
- Assert rst for 1 cycle while both buffers are full -> w_en=0 immediately; a_ready=b_ready=1 after release; no stale writes later.
- With RAISIN64_WB_BYPASS_EN: w_en=1, w_rn=7, w_data=0xABCD and r1_rn=7 in the same cycle -> next cycle r1_fwd=1, r1_fwd_data=0xABCD. Same with r1_rn=0 -> r1_fwd=0. Without the macro, r1_fwd is always 0.
